// File: rtl/cpu_clk_dbg_ctrl.sv
// CPU clock divider with run/step/halt control, debounced step button, rise counter and LED stretchers.
// All state on clk_gen_i; CLK edges are registered, so CLK and CLK_RISE change together.
module cpu_clk_dbg_ctrl #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100000000,
  parameter int unsigned DBG_CH      = 8,
  parameter int unsigned STRETCH_W   = 24,
  parameter int unsigned DEB_W       = 20
) (
  input  logic              clk_gen_i,
  input  logic              rst_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  div_val_i,
  input  logic [1:0]        mode_i,
  input  logic              step_btn_i,
  input  logic [DBG_CH-1:0] dbg_in_i,
  output logic              clk_o,
  output logic              clk_rise_o,
  output logic [31:0]       cycle_cnt_o,
  output logic              step_pending_o,
  output logic [DBG_CH-1:0] dbg_led_o
);

  localparam logic [1:0]           MODE_RUN  = 2'b00;
  localparam logic [1:0]           MODE_STEP = 2'b01;
  localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]     DIV_RST   = DIV_W'(DEFAULT_DIV);
  localparam logic [DEB_W-1:0]     DEB_LAST  = {DEB_W{1'b1}} - DEB_W'(1);
  localparam logic [STRETCH_W-1:0] STR_MAX   = {STRETCH_W{1'b1}};

  logic [DIV_W-1:0]     div_reg_q, div_reg_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic [31:0]          cyc_q, cyc_d;
  logic                 pend_q, pend_d;
  logic                 sync1_q, sync2_q;
  logic                 stable_q, stable_d;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [STRETCH_W-1:0] str_q [DBG_CH];
  logic [STRETCH_W-1:0] str_d [DBG_CH];

  logic counting, wrap, toggle, deb_diff, deb_flip, press;

  // Button debounce: flip the stable level once the synced input has disagreed long enough.
  always_comb begin
    deb_diff  = (sync2_q != stable_q);
    deb_flip  = deb_diff && (deb_cnt_q == DEB_LAST);
    stable_d  = stable_q ^ deb_flip;
    press     = deb_flip && !stable_q;
    deb_cnt_d = '0;
    if (deb_diff && !deb_flip) begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // A high phase always runs to its fall; a low phase only advances in RUN or on a pending step.
  always_comb begin
    counting  = clk_q || (mode_i == MODE_RUN) || ((mode_i == MODE_STEP) && pend_q);
    wrap      = (cnt_q == div_reg_q - DIV_ONE);
    toggle    = !div_load_i && counting && wrap;
    div_reg_d = div_reg_q;
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    if (div_load_i) begin
      div_reg_d = (div_val_i == '0) ? DIV_ONE : div_val_i;
      cnt_d     = '0;
    end else if (!counting) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + DIV_ONE;
    end
  end

  always_comb begin
    rise_d = toggle && !clk_q;
    cyc_d  = rise_d ? cyc_q + 32'd1 : cyc_q;
    pend_d = pend_q;
    if (toggle && clk_q) begin
      pend_d = 1'b0;
    end else if (press && (mode_i == MODE_STEP)) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DBG_CH); i++) begin
      str_d[i] = str_q[i];
      if (dbg_in_i[i]) begin
        str_d[i] = STR_MAX;
      end else if (str_q[i] != '0) begin
        str_d[i] = str_q[i] - STRETCH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_gen_i or posedge rst_i) begin
    if (rst_i) begin
      div_reg_q <= DIV_RST;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      cyc_q     <= '0;
      pend_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
      for (int i = 0; i < int'(DBG_CH); i++) begin
        str_q[i] <= '0;
      end
    end else begin
      div_reg_q <= div_reg_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      cyc_q     <= cyc_d;
      pend_q    <= pend_d;
      sync1_q   <= step_btn_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      for (int i = 0; i < int'(DBG_CH); i++) begin
        str_q[i] <= str_d[i];
      end
    end
  end

  always_comb begin
    dbg_led_o = '0;
    for (int i = 0; i < int'(DBG_CH); i++) begin
      dbg_led_o[i] = (str_q[i] != '0);
    end
  end

  assign clk_o          = clk_q;
  assign clk_rise_o     = rise_q;
  assign cycle_cnt_o    = cyc_q;
  assign step_pending_o = pend_q;

endmodule
